// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use interlock for the ID/EX boundary.
// Per-channel EX/MEM bypass selects are registered into EX; stall/bubble are combinational.
module hazard_forward_unit #(
    parameter int AW       = 4,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_valid,
    input  logic [AW-1:0]        ex_dst,
    input  logic                 ex_we,
    input  logic                 ex_is_load,
    input  logic [AW-1:0]        mem_dst,
    input  logic                 mem_we,
    input  logic                 flush,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 bubble,
    output logic [CW-1:0]        stall_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [3:0]    STALL_INIT = 4'(LOAD_LAT - 1);
    localparam logic [AW-1:0] ZERO_ADDR  = '0;
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NSRC*2-1:0]   fwd_sel_q, fwd_sel_d, fwd_next_s;
    logic [CW-1:0]       stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0]     match_ex_s, match_mem_s;
    logic                hazard_s, stall_s, bubble_s;

    // Independent per-channel match; EX result is newer so it beats MEM.
    always_comb begin
        match_ex_s  = '0;
        match_mem_s = '0;
        fwd_next_s  = '0;
        for (int k = 0; k < NSRC; k++) begin
            match_ex_s[k]  = id_src_valid[k] & ex_we & (ex_dst == id_src[k*AW +: AW])
                             & (id_src[k*AW +: AW] != ZERO_ADDR);
            match_mem_s[k] = id_src_valid[k] & mem_we & (mem_dst == id_src[k*AW +: AW])
                             & (id_src[k*AW +: AW] != ZERO_ADDR);
            if (match_ex_s[k]) begin
                fwd_next_s[2*k +: 2] = 2'b01;
            end else if (match_mem_s[k]) begin
                fwd_next_s[2*k +: 2] = 2'b11;
            end else begin
                fwd_next_s[2*k +: 2] = 2'b00;
            end
        end
        hazard_s = ex_is_load & (|match_ex_s);
    end

    // Interlock FSM: next state, down-counter, select load and stall/bubble.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fwd_sel_d = '0;
        stall_s   = 1'b0;
        bubble_s  = 1'b0;
        if (flush) begin
            state_d  = ST_RUN;
            cnt_d    = 4'd0;
            bubble_s = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard_s) begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = STALL_INIT;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        fwd_sel_d = fwd_next_s;
                    end
                end
                ST_STALL: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    // cnt==1 marks the last held cycle; RUN re-evaluates next.
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, selects and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces the combinational controls low even with hazardous inputs.
    assign stall     = stall_s & rst_n;
    assign bubble    = bubble_s & rst_n;
    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: two instances (LOAD_LAT=1/CW=16 and LOAD_LAT=3/CW=2) on shared inputs,
// checked against a remaining-stall-count reference model, a vector table and hand sequences.
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] id_src;
    logic [1:0] id_src_valid;
    logic [3:0] ex_dst;
    logic       ex_we;
    logic       ex_is_load;
    logic [3:0] mem_dst;
    logic       mem_we;
    logic       flush;

    logic [3:0]  fwd0, fwd1;
    logic        stall0, stall1, bubble0, bubble1;
    logic [15:0] scnt0;
    logic [1:0]  scnt1;

    hazard_forward_unit #(.AW(4), .NSRC(2), .LOAD_LAT(1), .CW(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_valid(id_src_valid),
        .ex_dst(ex_dst), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .mem_dst(mem_dst), .mem_we(mem_we), .flush(flush),
        .fwd_sel(fwd0), .stall(stall0), .bubble(bubble0), .stall_cnt(scnt0)
    );

    hazard_forward_unit #(.AW(4), .NSRC(2), .LOAD_LAT(3), .CW(2)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_valid(id_src_valid),
        .ex_dst(ex_dst), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .mem_dst(mem_dst), .mem_we(mem_we), .flush(flush),
        .fwd_sel(fwd1), .stall(stall1), .bubble(bubble1), .stall_cnt(scnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining forced-stall cycles, pending selects, stall count.
    int         rem  [2];
    logic [3:0] mfwd [2];
    int         mcnt [2];
    int         lat  [2];
    int         cmax [2];
    logic       s_stall  [2];
    logic       s_bubble [2];

    typedef struct {
        logic [7:0] src;
        logic [1:0] srcv;
        logic [3:0] ex_dst;
        logic       ex_we;
        logic       ex_ld;
        logic [3:0] mem_dst;
        logic       mem_we;
        logic       flush;
        logic       exp_stall;
        logic       exp_bubble;
        logic [3:0] exp_fwd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit ch_match(input int k, input logic [3:0] dst, input logic we);
        logic [3:0] s;
        s = id_src[k*4 +: 4];
        return id_src_valid[k] && we && (dst == s) && (s != 4'd0);
    endfunction

    function automatic bit hazard_now();
        return ex_is_load && (ch_match(0, ex_dst, ex_we) || ch_match(1, ex_dst, ex_we));
    endfunction

    function automatic logic [3:0] sel_now();
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 2; k++) begin
            if (ch_match(k, ex_dst, ex_we))        r[2*k +: 2] = 2'b01;
            else if (ch_match(k, mem_dst, mem_we)) r[2*k +: 2] = 2'b11;
        end
        return r;
    endfunction

    function automatic bit model_stall(input int i);
        return !flush && (rem[i] > 0 || hazard_now());
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; mfwd[i] = 4'd0; mcnt[i] = 0;
        end
    endtask

    task automatic set_in(input logic [7:0] s, input logic [1:0] v, input logic [3:0] ed,
                          input logic ew, input logic el, input logic [3:0] md,
                          input logic mw, input logic fl);
        id_src = s; id_src_valid = v; ex_dst = ed; ex_we = ew; ex_is_load = el;
        mem_dst = md; mem_we = mw; flush = fl;
    endtask

    // One clock: compare everything at the negedge, then advance the model at the posedge.
    task automatic cycle();
        bit ms;
        @(negedge clk);
        s_stall[0] = stall0; s_bubble[0] = bubble0;
        s_stall[1] = stall1; s_bubble[1] = bubble1;
        for (int i = 0; i < 2; i++) begin
            ms = model_stall(i);
            chk($sformatf("stall%0d", i), 32'(s_stall[i]), 32'(ms));
            chk($sformatf("bubble%0d", i), 32'(s_bubble[i]), 32'(flush || ms));
            chk($sformatf("fwd_sel%0d", i), (i == 0) ? 32'(fwd0) : 32'(fwd1), 32'(mfwd[i]));
            chk($sformatf("stall_cnt%0d", i), (i == 0) ? 32'(scnt0) : 32'(scnt1), 32'(mcnt[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            ms = model_stall(i);
            if (ms && mcnt[i] < cmax[i]) mcnt[i]++;
            if (flush) begin
                rem[i] = 0; mfwd[i] = 4'd0;
            end else if (rem[i] > 0) begin
                rem[i]--; mfwd[i] = 4'd0;
            end else if (hazard_now()) begin
                rem[i] = lat[i] - 1; mfwd[i] = 4'd0;
            end else begin
                mfwd[i] = sel_now();
            end
        end
        #1;
    endtask

    // Asynchronous reset: outputs must drop before any clock edge, inputs left as they were.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst fwd0", 32'(fwd0), 32'd0);
        chk("rst fwd1", 32'(fwd1), 32'd0);
        chk("rst stall0", 32'(stall0), 32'd0);
        chk("rst stall1", 32'(stall1), 32'd0);
        chk("rst bubble0", 32'(bubble0), 32'd0);
        chk("rst bubble1", 32'(bubble1), 32'd0);
        chk("rst cnt0", 32'(scnt0), 32'd0);
        chk("rst cnt1", 32'(scnt1), 32'd0);
        model_clear();
        set_in(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic hazard_in(input logic fl);
        set_in(8'h49, 2'b11, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, fl);
    endtask

    task automatic benign_in();
        set_in(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        lat  = '{1, 3};
        cmax = '{65535, 3};
        rst_n = 1'b1;
        benign_in();
        model_clear();
        #2;
        do_reset();

        //        src     v      exd   ewe   eld   memd  mwe   fl    stall bub   fwd
        tbl[0]  = '{8'h33, 2'b11, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101};
        tbl[1]  = '{8'h65, 2'b11, 4'd6, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111};
        tbl[2]  = '{8'h65, 2'b11, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001};
        tbl[3]  = '{8'h00, 2'b11, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[4]  = '{8'h00, 2'b11, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[5]  = '{8'h77, 2'b00, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[6]  = '{8'h77, 2'b10, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
        tbl[7]  = '{8'h22, 2'b11, 4'd2, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111};
        tbl[8]  = '{8'h49, 2'b11, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
        tbl[9]  = '{8'h49, 2'b11, 4'd4, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100};
        tbl[10] = '{8'h49, 2'b11, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
        tbl[11] = '{8'h49, 2'b11, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011};

        for (int r = 0; r < 12; r++) begin
            set_in(tbl[r].src, tbl[r].srcv, tbl[r].ex_dst, tbl[r].ex_we, tbl[r].ex_ld,
                   tbl[r].mem_dst, tbl[r].mem_we, tbl[r].flush);
            cycle();
            chk($sformatf("tbl%0d stall", r), 32'(s_stall[0]), 32'(tbl[r].exp_stall));
            chk($sformatf("tbl%0d bubble", r), 32'(s_bubble[0]), 32'(tbl[r].exp_bubble));
            chk($sformatf("tbl%0d fwd_sel", r), 32'(fwd0), 32'(tbl[r].exp_fwd));
        end
        chk("lat1 stall_cnt", 32'(scnt0), 32'd1);

        // LOAD_LAT=3: exactly three consecutive stall cycles.
        do_reset();
        hazard_in(1'b0);
        cycle();
        chk("lat3 stall c1", 32'(s_stall[1]), 32'd1);
        benign_in();
        cycle();
        chk("lat3 stall c2", 32'(s_stall[1]), 32'd1);
        cycle();
        chk("lat3 stall c3", 32'(s_stall[1]), 32'd1);
        cycle();
        chk("lat3 stall c4", 32'(s_stall[1]), 32'd0);

        // LOAD_LAT=3: flush in the second cycle aborts the stall.
        do_reset();
        hazard_in(1'b0);
        cycle();
        hazard_in(1'b1);
        cycle();
        chk("flush stall", 32'(s_stall[1]), 32'd0);
        chk("flush bubble", 32'(s_bubble[1]), 32'd1);
        chk("flush stall_cnt", 32'(scnt1), 32'd1);
        benign_in();
        cycle();
        chk("post-flush stall", 32'(s_stall[1]), 32'd0);

        // Saturation of the 2-bit counter after six stall cycles.
        do_reset();
        hazard_in(1'b0);
        for (int c = 0; c < 6; c++) cycle();
        chk("sat stall_cnt lat3", 32'(scnt1), 32'd3);
        chk("sat stall_cnt lat1", 32'(scnt0), 32'd6);
        benign_in();
        cycle();

        // Reset while the LOAD_LAT=3 instance is mid-stall, hazard still on the inputs.
        do_reset();
        hazard_in(1'b0);
        cycle();
        do_reset();
        cycle();
        chk("post-rst stall", 32'(s_stall[1]), 32'd0);
        cycle();

        // Random traffic over a small address space to provoke matches.
        for (int c = 0; c < 400; c++) begin
            set_in({4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                   2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 2) == 0),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
